// File: rtl/pio_in_edge_capture_pkg.sv
// pio_pkg: register addresses, edge type and width limit for the PIO edge-capture input slave
package pio_pkg;
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;
  localparam int PIO_MAX_WIDTH = 32;
  typedef enum logic [1:0] {EDGE_RISE, EDGE_FALL, EDGE_ANY} edge_t;
endpackage

// File: rtl/pio_in_edge_capture_if.sv
// pio_in_edge_capture_if: Avalon-MM slave bus plus interrupt line
interface pio_in_edge_capture_if;
  import pio_pkg::*;
  logic [1:0] address;
  logic chipselect;
  logic write;
  logic [PIO_MAX_WIDTH-1:0] writedata;
  logic [PIO_MAX_WIDTH-1:0] readdata;
  logic irq;
  modport master(output address, chipselect, write, writedata, input readdata, irq);
  modport slave(input address, chipselect, write, writedata, output readdata, irq);
endinterface

// File: rtl/pio_in_edge_capture_sync_edge.sv
// pio_sync_edge: one-bit synchroniser chain, previous-value flop and edge pulse
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter edge_t EDGE_TYPE = EDGE_RISE
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic edge_p
);
  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      chain <= '0;
      prev <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev <= sync;
    end
  assign sync = chain[SYNC_STAGES-1];
  assign edge_p = EDGE_TYPE == EDGE_RISE ? sync & ~prev :
                  EDGE_TYPE == EDGE_FALL ? ~sync & prev : sync ^ prev;
endmodule

// File: rtl/pio_in_edge_capture.sv
// pio_in_edge_capture: synchronised PIO input with sticky edge capture, mask and level irq
// PIO_IN_BITCLR_EN: EDGECAP writes clear only the bits set in writedata (default clears all)
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_WIDTH-1:0] in_port,
  pio_in_edge_capture_if.slave bus
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARMED = CW'(SYNC_STAGES + 1);
  logic [DATA_WIDTH-1:0] sync, edge_p, irqmask, edgecap, clr;
  logic [CW-1:0] arm_cnt;
  logic armed, wr;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    pio_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(edge_t'(EDGE_TYPE))) u_se (
      .clk(clk), .reset(reset), .din(in_port[i]), .sync(sync[i]), .edge_p(edge_p[i])
    );
  end
  assign armed = arm_cnt == ARMED;
  assign wr = bus.chipselect & bus.write;
  always_comb begin
`ifdef PIO_IN_BITCLR_EN
    clr = wr && bus.address == PIO_ADDR_EDGECAP ? bus.writedata[DATA_WIDTH-1:0] : '0;
`else
    clr = wr && bus.address == PIO_ADDR_EDGECAP ? '1 : '0;
`endif
  end
  // new edges are OR-ed in after the clear so a coincident event survives
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      arm_cnt <= '0;
      irqmask <= '0;
      edgecap <= '0;
      bus.readdata <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
      if (wr && bus.address == PIO_ADDR_IRQMASK) irqmask <= bus.writedata[DATA_WIDTH-1:0];
      edgecap <= (edgecap & ~clr) | (edge_p & {DATA_WIDTH{armed}});
      bus.readdata <= bus.address == PIO_ADDR_DATA    ? 32'(sync) :
                      bus.address == PIO_ADDR_IRQMASK ? 32'(irqmask) :
                      bus.address == PIO_ADDR_EDGECAP ? 32'(edgecap) : '0;
    end
  assign bus.irq = |(edgecap & irqmask);
endmodule

// File: tb/tb_pio_in_edge_capture.sv
// tb_pio_in_edge_capture: scoreboard bench for an 8-bit rising-edge and a 32-bit any-edge instance
module tb_pio_in_edge_capture;
  logic clk, reset;
  logic [7:0] in_a;
  logic [31:0] in_b;
  int total = 0, bad = 0;
  typedef struct {string tag; int sel; logic [31:0] exp;} item_t;
  item_t q[$];
  pio_in_edge_capture_if ba();
  pio_in_edge_capture_if bb();
  pio_in_edge_capture #(.DATA_WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset), .in_port(in_a), .bus(ba.slave));
  pio_in_edge_capture #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .in_port(in_b), .bus(bb.slave));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int s);
    return s == 0 ? ba.readdata : s == 1 ? {31'b0, ba.irq} : s == 2 ? bb.readdata : {31'b0, bb.irq};
  endfunction
  task automatic expect_q(input int sel, input string tag, input logic [31:0] exp);
    item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    q.push_back(it);
  endtask
  task automatic cyc();
    item_t it;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      it = q.pop_front();
      chk(it.tag, obs(it.sel), it.exp);
    end
  endtask
  task automatic bus_set(input bit b, input logic [1:0] a, input logic cs, input logic w, input logic [31:0] wd);
    if (b) begin
      bb.address = a; bb.chipselect = cs; bb.write = w; bb.writedata = wd;
    end else begin
      ba.address = a; ba.chipselect = cs; ba.write = w; ba.writedata = wd;
    end
  endtask
  task automatic rd(input bit b, input logic [1:0] a, input string tag, input logic [31:0] exp);
    bus_set(b, a, 1'b1, 1'b0, 32'h0);
    expect_q(b ? 2 : 0, tag, exp);
    cyc();
  endtask
  task automatic wr(input bit b, input logic [1:0] a, input logic [31:0] wd);
    bus_set(b, a, 1'b1, 1'b1, wd);
    cyc();
    bus_set(b, a, 1'b0, 1'b0, 32'h0);
  endtask
  initial begin
    reset = 1;
    in_a = 8'hFF;
    in_b = 32'h0;
    bus_set(0, 2'd0, 0, 0, 0);
    bus_set(1, 2'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", ba.readdata, 32'h0);
    chk("rst_irq", {31'b0, ba.irq}, 32'h0);
    reset = 0;
    bus_set(0, 2'd3, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      expect_q(0, "arm_cap", 32'h0);
      expect_q(1, "arm_irq", 32'h0);
      cyc();
    end
    rd(0, 2'd0, "data_ff", 32'h0000_00FF);
    in_a = 8'h00;
    repeat (6) cyc();
    wr(0, 2'd1, 32'h04);
    rd(0, 2'd1, "mask", 32'h04);
    rd(0, 2'd3, "cap_fall_ign", 32'h0);
    bus_set(0, 2'd0, 1, 0, 0);
    in_a = 8'h05;
    expect_q(1, "irq_c1", 32'h0);
    cyc();
    expect_q(1, "irq_c2", 32'h0);
    cyc();
    expect_q(1, "irq_c3", 32'h1);
    expect_q(0, "data_05", 32'h05);
    cyc();
    rd(0, 2'd3, "cap_rise", 32'h05);
    bus_set(0, 2'd3, 1, 1, 32'h01);
`ifdef PIO_IN_BITCLR_EN
    expect_q(1, "clr_irq", 32'h1);
    cyc();
    bus_set(0, 2'd3, 0, 0, 0);
    rd(0, 2'd3, "clr_cap", 32'h04);
`else
    expect_q(1, "clr_irq", 32'h0);
    cyc();
    bus_set(0, 2'd3, 0, 0, 0);
    rd(0, 2'd3, "clr_cap", 32'h00);
`endif
    in_a = 8'h04;
    repeat (4) cyc();
    in_a = 8'h05;
    cyc();
    cyc();
    bus_set(0, 2'd3, 1, 1, 32'hFF);
    expect_q(1, "setwin_irq", 32'h0);
    cyc();
    bus_set(0, 2'd3, 0, 0, 0);
    rd(0, 2'd3, "set_wins", 32'h01);
    wr(0, 2'd2, 32'hFF);
    rd(0, 2'd2, "rsvd", 32'h0);
    rd(0, 2'd1, "mask_keep", 32'h04);
    wr(0, 2'd1, 32'hFFFF_FF0F);
    expect_q(1, "mask_irq", 32'h1);
    rd(0, 2'd1, "mask_trunc", 32'h0F);
    bus_set(1, 2'd3, 0, 0, 0);
    in_b = 32'h8000_0000;
    repeat (4) cyc();
    rd(1, 2'd3, "b_cap_rise", 32'h8000_0000);
    wr(1, 2'd3, 32'h8000_0000);
    rd(1, 2'd3, "b_clr", 32'h0);
    in_b = 32'h0;
    repeat (4) cyc();
    rd(1, 2'd3, "b_cap_fall", 32'h8000_0000);
    rd(1, 2'd2, "b_rsvd", 32'h0);
    expect_q(3, "b_irq", 32'h0);
    rd(1, 2'd0, "b_data", 32'h0);
    in_a = 8'h00;
    repeat (4) cyc();
    wr(0, 2'd3, 32'hFF);
    in_a = 8'h0F;
    repeat (4) cyc();
    rd(0, 2'd3, "cap_0f", 32'h0F);
    wr(0, 2'd1, 32'hFF);
    expect_q(1, "pre_rst_irq", 32'h1);
    rd(0, 2'd3, "pre_rst_cap", 32'h0F);
    #2;
    reset = 1;
    #1;
    chk("arst_rd", ba.readdata, 32'h0);
    chk("arst_irq", {31'b0, ba.irq}, 32'h0);
    chk("arst_b_rd", bb.readdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      expect_q(0, "rearm_cap", 32'h0);
      expect_q(1, "rearm_irq", 32'h0);
      cyc();
    end
    rd(0, 2'd1, "mask_rst", 32'h0);
    rd(0, 2'd0, "data_rst", 32'h0F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pio_in_edge_capture.md
Name: pio_in_edge_capture

Overview:
- Parametrised successor to the fixed 8-bit read-only PIO input slave.
- Avalon-MM slave that synchronises an external input bus of DATA_WIDTH bits and returns it on a data register.
- Adds per-bit edge capture, an interrupt mask, and a level interrupt to the Nios II, for switches, buttons and status lines crossing in from other clock domains.

Parameters:
- DATA_WIDTH, 8: input bus width, legal 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, legal 2..4.
- EDGE_TYPE, 0: edge that sets a capture bit. 0 = rising, 1 = falling, 2 = any.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select, qualifies writes.
- write  in  1  active-high write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  DATA_WIDTH  external asynchronous inputs.
- irq  out  1  level interrupt.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. All state resets to 0 immediately on reset assertion.
- Reset values: readdata=0, irq=0, sync chain=0, prev=0, irqmask=0, edgecap=0, arm counter=0.
- Register map, selected by address:
  - 0 DATA: read-only, synchronised in_port.
  - 1 IRQMASK: R/W, DATA_WIDTH bits.
  - 2 reserved: reads 0, writes ignored.
  - 3 EDGECAP: read, write-to-clear.
- Reads:
  - readdata <= zero-extended mux(address), updated every clock regardless of chipselect.
  - Read latency is 1 cycle.
  - Bits [31:DATA_WIDTH] always read 0.
- Writes take effect when chipselect && write at the clock edge. writedata bits above DATA_WIDTH are ignored.
- Synchroniser:
  - SYNC_STAGES flops per bit; sync = last stage.
  - prev <= sync every cycle.
  - Rising edge = sync & ~prev. Falling edge = ~sync & prev. Any edge = sync ^ prev.
- Latency: an in_port change is visible on DATA after SYNC_STAGES clocks. The matching EDGECAP bit is set one clock later. irq follows EDGECAP combinationally.
- Arming:
  - A counter of width clog2(SYNC_STAGES+2) counts from 0 to SYNC_STAGES+1, then saturates.
  - Edge detection is suppressed until the counter saturates. This prevents spurious captures from inputs already high at reset release.
- EDGECAP sets: bit i sets on a detected edge and stays set until cleared (sticky).
- Simultaneous set and clear on the same bit in the same cycle: the set wins; no event is lost.
- irq = |(edgecap & irqmask). It is driven from registers only; no combinational path from the bus.
- Reset mid-operation: all captures and the mask are lost, and arming restarts.

Optional Feature:
- Macro: PIO_IN_BITCLR_EN.
- Defined: a write to address 3 clears only the EDGECAP bits where writedata[i]=1; other bits are held.
- Undefined: any write to address 3 clears all EDGECAP bits, regardless of writedata.
- The set-wins rule applies in both builds.

Decomposition:
- Package pio_pkg:
  - Address constants PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=1, PIO_ADDR_EDGECAP=3.
  - Edge type enum EDGE_RISE/EDGE_FALL/EDGE_ANY.
  - Data width limit constant PIO_MAX_WIDTH=32.
- Sub-module pio_sync_edge: one bit, holding the synchroniser chain, prev flop and edge pulse. Instantiated DATA_WIDTH times in a generate loop. Register file, arming counter and read mux stay in the top module.

Test Plan:
- Reset with in_port=8'hFF held high through release; wait 10 clocks -> DATA reads 0x000000FF, EDGECAP reads 0, irq=0.
- EDGE_TYPE=0, in_port 0x00->0x05 -> DATA=0x05 after 2 clocks, EDGECAP=0x05 on the 3rd clock. With IRQMASK=0x04, irq=1 on that same cycle.
- Clear test with EDGECAP=0x05, write 0x01 to address 3:
  - With PIO_IN_BITCLR_EN: EDGECAP=0x04, irq stays 1.
  - Without: EDGECAP=0x00, irq=0.
- Clear write to address 3 in the same cycle as a new edge on bit 0 -> bit 0 remains 1.
- DATA_WIDTH=32, EDGE_TYPE=2, toggle bit 31 high then low with a clear in between -> EDGECAP bit 31 is set both times. Reads of address 2 always return 0.
- Assert reset asynchronously mid-transfer (between clock edges) with EDGECAP=0x0F and IRQMASK=0xFF -> readdata, irq, IRQMASK and EDGECAP go to 0 immediately, and no capture occurs during re-arming.
